// File: rtl/rr_arb_mux_pkg.sv
// Shared types and the round-robin pick function for rr_arb_mux.
// Channel indices are carried at the package-wide maximum width and narrowed by each user.
package rr_arb_mux_pkg;

  localparam int RR_N_MAX     = 64;
  localparam int RR_SEL_W_MAX = 6;

  typedef logic [RR_SEL_W_MAX-1:0] chan_idx_t;

  localparam chan_idx_t RR_PTR_RESET = '0;

  typedef struct packed {
    logic                found;
    chan_idx_t           idx;
    logic [RR_N_MAX-1:0] grant;
  } rr_pick_t;

  // Two passes: first ptr..n-1, then 0..ptr-1, so the first hit is the round-robin winner.
  function automatic rr_pick_t rr_pick(input logic [RR_N_MAX-1:0] valid,
                                       input chan_idx_t           ptr,
                                       input int                  n);
    rr_pick_t r;
    logic     hit;
    r = '0;
    for (int pass = 0; pass < 2; pass++) begin
      for (int i = 0; i < RR_N_MAX; i++) begin
        hit = !r.found && valid[i] && (i < n) &&
              ((pass == 0) ? (i >= int'(ptr)) : (i < int'(ptr)));
        if (hit) begin
          r.found    = 1'b1;
          r.idx      = chan_idx_t'(i);
          r.grant[i] = 1'b1;
        end else begin
          r.found = r.found;
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter owning rr_ptr; with RR_ARB_MUX_LOCK_EN it also owns the channel lock.
module rr_arbiter #(
  parameter  int N_INPUTS = 8,
  localparam int SEL_W    = $clog2(N_INPUTS)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [N_INPUTS-1:0] req,
  input  logic                advance,
  input  logic [SEL_W-1:0]    adv_idx,
`ifdef RR_ARB_MUX_LOCK_EN
  input  logic                adv_lock,
`endif
  output logic [N_INPUTS-1:0] grant,
  output logic [SEL_W-1:0]    grant_idx
);
  import rr_arb_mux_pkg::*;

  logic [SEL_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [SEL_W-1:0]    next_ptr;
  logic [RR_N_MAX-1:0] req_pad;
  rr_pick_t            pick;
  logic                unused_pick;

  // Round-robin candidate from the current pointer.
  always_comb begin
    req_pad                = '0;
    req_pad[N_INPUTS-1:0]  = req;
    pick                   = rr_pick(req_pad, chan_idx_t'(rr_ptr_q), N_INPUTS);
  end

  assign unused_pick = ^pick;
  assign next_ptr    = (adv_idx == SEL_W'(N_INPUTS - 1)) ? SEL_W'(0) : adv_idx + SEL_W'(1);

`ifdef RR_ARB_MUX_LOCK_EN
  logic             lock_q, lock_d;
  logic [SEL_W-1:0] lock_idx_q, lock_idx_d;

  // A held lock overrides rotation: only the locked channel may win, even when it idles.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    if (lock_q) begin
      grant[lock_idx_q] = req[lock_idx_q];
      grant_idx         = lock_idx_q;
    end else begin
      grant     = pick.grant[N_INPUTS-1:0];
      grant_idx = pick.idx[SEL_W-1:0];
    end
  end

  // Pointer and lock update on an accepted word.
  always_comb begin
    rr_ptr_d   = rr_ptr_q;
    lock_d     = lock_q;
    lock_idx_d = lock_idx_q;
    if (advance) begin
      if (adv_lock) begin
        lock_d     = 1'b1;
        lock_idx_d = adv_idx;
      end else begin
        lock_d   = 1'b0;
        rr_ptr_d = next_ptr;
      end
    end else begin
      rr_ptr_d = rr_ptr_q;
    end
  end

  // Lock state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
    end else begin
      lock_q     <= lock_d;
      lock_idx_q <= lock_idx_d;
    end
  end
`else
  // Pure round-robin grant.
  always_comb begin
    grant     = pick.grant[N_INPUTS-1:0];
    grant_idx = pick.idx[SEL_W-1:0];
  end

  // Pointer moves past the channel just served.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (advance) begin
      rr_ptr_d = next_ptr;
    end else begin
      rr_ptr_d = rr_ptr_q;
    end
  end
`endif

  // Round-robin pointer register.
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr_q <= RR_PTR_RESET[SEL_W-1:0];
    end else begin
      rr_ptr_q <= rr_ptr_d;
    end
  end

endmodule

// File: rtl/rr_arb_mux.sv
// N-channel round-robin mux with a one-entry registered output and valid/ready on both sides.
// Optional build macro RR_ARB_MUX_LOCK_EN adds the in_lock port and channel locking.
module rr_arb_mux #(
  parameter  int WIDTH    = 32,
  parameter  int N_INPUTS = 8,
  localparam int SEL_W    = $clog2(N_INPUTS)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [N_INPUTS*WIDTH-1:0] in_data,
  input  logic [N_INPUTS-1:0]       in_valid,
  output logic [N_INPUTS-1:0]       in_ready,
`ifdef RR_ARB_MUX_LOCK_EN
  input  logic [N_INPUTS-1:0]       in_lock,
`endif
  output logic [WIDTH-1:0]          out_data,
  output logic [SEL_W-1:0]          out_sel,
  output logic                      out_valid,
  input  logic                      out_ready
);
  import rr_arb_mux_pkg::*;

  logic [N_INPUTS-1:0] grant;
  logic [SEL_W-1:0]    grant_idx;
  logic                can_load;
  logic                load;
  logic [N_INPUTS-1:0] in_ready_s;

  logic [WIDTH-1:0]    out_data_q, out_data_d;
  logic [SEL_W-1:0]    out_sel_q, out_sel_d;
  logic                out_valid_q, out_valid_d;

  rr_arbiter #(.N_INPUTS(N_INPUTS)) u_arb (
    .clk       (clk),
    .reset     (reset),
    .req       (in_valid),
    .advance   (load),
    .adv_idx   (grant_idx),
`ifdef RR_ARB_MUX_LOCK_EN
    .adv_lock  (in_lock[grant_idx]),
`endif
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  // Accept only when the output slot is free or draining this cycle; never during reset.
  always_comb begin
    can_load = !out_valid_q || out_ready;
    if (reset) begin
      in_ready_s = '0;
    end else if (can_load) begin
      in_ready_s = grant;
    end else begin
      in_ready_s = '0;
    end
    load = |in_ready_s;
  end

  // Output slot next state: reload wins over drain so a word can pass every cycle.
  always_comb begin
    out_data_d  = out_data_q;
    out_sel_d   = out_sel_q;
    out_valid_d = out_valid_q;
    if (load) begin
      out_data_d  = in_data[int'(grant_idx)*WIDTH +: WIDTH];
      out_sel_d   = grant_idx;
      out_valid_d = 1'b1;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // Output register.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_data_q  <= '0;
      out_sel_q   <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_data_q  <= out_data_d;
      out_sel_q   <= out_sel_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_s;
  assign out_data  = out_data_q;
  assign out_sel   = out_sel_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_rr_arb_mux.sv
// Directed bench for rr_arb_mux: expected words are queued at issue and checked by a monitor.
module tb_rr_arb_mux;
  localparam int WIDTH = 32;
  localparam int N     = 8;
  localparam int SEL_W = 3;

  typedef struct packed {
    logic [SEL_W-1:0] sel;
    logic [WIDTH-1:0] data;
  } exp_t;

  logic                 clk = 1'b0;
  logic                 reset;
  logic [N*WIDTH-1:0]   in_data;
  logic [N-1:0]         in_valid;
  logic [N-1:0]         in_ready;
  logic [N-1:0]         in_lock;
  logic [WIDTH-1:0]     out_data;
  logic [SEL_W-1:0]     out_sel;
  logic                 out_valid;
  logic                 out_ready;

  exp_t sb[$];
  exp_t mon_e;
  int   n_cmp  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  rr_arb_mux #(.WIDTH(WIDTH), .N_INPUTS(N)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
`ifdef RR_ARB_MUX_LOCK_EN
    .in_lock   (in_lock),
`endif
    .out_data  (out_data),
    .out_sel   (out_sel),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  function automatic logic [WIDTH-1:0] word(input int k);
    logic [WIDTH-1:0] base;
    base = 32'hA000_0000;
    return base | WIDTH'(k);
  endfunction

  function automatic logic [N-1:0] oh(input int k);
    logic [N-1:0] v;
    v    = '0;
    v[k] = 1'b1;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic push(input int k);
    exp_t e;
    e.sel  = SEL_W'(k);
    e.data = word(k);
    sb.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic ready_is(input string name, input logic [N-1:0] exp);
    @(negedge clk);
    chk(name, 64'(in_ready), 64'(exp));
  endtask

  // Scoreboard monitor: every output transfer must match the oldest queued expectation.
  always @(negedge clk) begin
    if (reset === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_output: actual sel=%0d data=%0h required none", out_sel, out_data);
      end else begin
        mon_e = sb.pop_front();
        chk("out_sel", 64'(out_sel), 64'(mon_e.sel));
        chk("out_data", 64'(out_data), 64'(mon_e.data));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int k = 0; k < N; k++) in_data[k*WIDTH +: WIDTH] = word(k);
    in_lock   = '0;
    out_ready = 1'b1;

    // Reset with every channel requesting.
    reset    = 1'b1;
    in_valid = '1;
    ready_is("rst_ready_c0", '0);
    step();
    ready_is("rst_ready_c1", '0);
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_out_data", 64'(out_data), 64'(0));
    chk("rst_out_sel", 64'(out_sel), 64'(0));
    step();
    reset = 1'b0;

    // Full rotation 0..7 then 0 at one word per cycle.
    for (int i = 0; i < N + 1; i++) begin
      push(i % N);
      ready_is("rr_ready", oh(i % N));
      step();
    end
    in_valid = '0;
    step();
    step();

    // Backpressure with ch2 and ch5 requesting; rr_ptr is 1 here.
    in_valid  = oh(2) | oh(5);
    out_ready = 1'b0;
    push(2);
    ready_is("bp_load_ready", oh(2));
    step();
    for (int i = 0; i < 5; i++) begin
      ready_is("bp_stall_ready", '0);
      chk("bp_hold_data", 64'(out_data), 64'(word(2)));
      chk("bp_hold_valid", 64'(out_valid), 64'(1));
      step();
    end
    out_ready = 1'b1;
    push(5);
    push(2);
    ready_is("bp_rel_ready5", oh(5));
    step();
    ready_is("bp_rel_ready2", oh(2));
    step();
    in_valid = '0;
    step();
    step();
    step();

    // Sparse requests: ch7, then ch0 (pointer wrapped), then ch0|ch1 picks ch1.
    in_valid = oh(7);
    push(7);
    ready_is("wrap_ready7", oh(7));
    step();
    in_valid = oh(0);
    push(0);
    ready_is("wrap_ready0", oh(0));
    step();
    in_valid = oh(0) | oh(1);
    push(1);
    ready_is("wrap_ready1", oh(1));
    step();
    in_valid = '0;
    step();
    step();

    // Reset while a word is stalled in the output register; that word is discarded.
    out_ready = 1'b0;
    in_valid  = '1;
    push(2);
    ready_is("midrst_pre_ready", oh(2));
    step();
    reset = 1'b1;
    sb.delete();
    ready_is("midrst_ready", '0);
    step();
    @(negedge clk);
    chk("midrst_out_valid", 64'(out_valid), 64'(0));
    chk("midrst_out_sel", 64'(out_sel), 64'(0));
    chk("midrst_out_data", 64'(out_data), 64'(0));
    step();
    reset     = 1'b0;
    out_ready = 1'b1;
    push(0);
    ready_is("midrst_restart", oh(0));
    step();
    in_valid = '0;
    step();
    step();

`ifdef RR_ARB_MUX_LOCK_EN
    // ch3 holds the lock for two words while ch4 waits, then releases.
    in_valid = oh(3) | oh(4);
    in_lock  = oh(3);
    push(3);
    push(3);
    push(3);
    push(4);
    ready_is("lock_ready_a", oh(3));
    step();
    ready_is("lock_ready_b", oh(3));
    step();
    in_lock = '0;
    ready_is("lock_ready_c", oh(3));
    step();
    in_valid = oh(4);
    ready_is("lock_ready_4", oh(4));
    step();
    in_valid = '0;
    step();
    step();
`endif

    for (int i = 0; i < 20 && sb.size() != 0; i++) step();
    chk("sb_drained", 64'(sb.size()), 64'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
